// File: rtl/wbs_ctrl.sv
// Wishbone slave bridge from the management bus to the ANN accelerator
// control registers and debug-access memory ports.
module wbs_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 24,
    parameter int COL_SIZE   = 17,
    parameter int K          = 4,
    parameter int NUM_LEAVES = 64,
    localparam int PW = PATCH_SIZE * DATA_WIDTH,
    localparam int QW = $clog2(ROW_SIZE * COL_SIZE),
    localparam int LW = $clog2(NUM_LEAVES),
    localparam int BW = $clog2(LEAF_SIZE)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_adr_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_mode,
    output logic                 wbs_debug,
    output logic                 wbs_qp_mem_csb0,
    output logic                 wbs_qp_mem_web0,
    output logic [QW-1:0]        wbs_qp_mem_addr0,
    output logic [PW-1:0]        wbs_qp_mem_wpatch0,
    input  logic [PW-1:0]        wbs_qp_mem_rpatch0,
    output logic [LEAF_SIZE-1:0] wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0] wbs_leaf_mem_web0,
    output logic [LW-1:0]        wbs_leaf_mem_addr0,
    output logic [63:0]          wbs_leaf_mem_wleaf0,
    input  logic [63:0]          wbs_leaf_mem_rleaf0 [LEAF_SIZE],
    output logic                 wbs_node_mem_web,
    output logic [31:0]          wbs_node_mem_addr,
    output logic [31:0]          wbs_node_mem_wdata,
    input  logic [31:0]          wbs_node_mem_rdata,
    output logic                 wbs_best_arr_csb1,
    output logic [7:0]           wbs_best_arr_addr1,
    input  logic [63:0]          wbs_best_arr_rdata1
);

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, ACK} state_e;
    typedef enum logic [2:0] {
        R_REG, R_QP, R_LEAF, R_BEST, R_NODE, R_NONE
    } rgn_e;

    state_e state_q, state_d;
    rgn_e   rgn, rgn_q, rgn_d;
    logic   up, up_q, up_d;
    logic [BW-1:0] bank, bank_q, bank_d;

    logic        ack_q, ack_d, mode_q, mode_d, debug_q, debug_d;
    logic [31:0] dat_q, dat_d, hold_q, hold_d;
    logic        qcsb_q, qcsb_d, qweb_q, qweb_d;
    logic [QW-1:0] qaddr_q, qaddr_d;
    logic [PW-1:0] wpatch_q, wpatch_d;
    logic [LEAF_SIZE-1:0] lcsb_q, lcsb_d, lweb_q, lweb_d;
    logic [LW-1:0] laddr_q, laddr_d;
    logic [63:0] wleaf_q, wleaf_d;
    logic        nweb_q, nweb_d;
    logic [31:0] naddr_q, naddr_d, nwdata_q, nwdata_d;
    logic        bcsb_q, bcsb_d;
    logic [7:0]  baddr_q, baddr_d;

    logic [63:0] rd64;
    logic [31:0] rd_half, reg_rd;
    logic        unused_ok;

    assign unused_ok = (^wbs_sel_i) ^ (K == 0);

    assign up   = wbs_adr_i[2];
    assign bank = wbs_adr_i[3+:BW];

    always_comb begin
        unique case (wbs_adr_i[31:16])
            16'h3000: rgn = R_REG;
            16'h3001: rgn = R_QP;
            16'h3002: rgn = R_LEAF;
            16'h3003: rgn = R_BEST;
            16'h3004: rgn = R_NODE;
            default:  rgn = R_NONE;
        endcase
    end

    always_comb begin
        unique case (rgn_q)
            R_QP:    rd64 = {{(64-PW){1'b0}}, wbs_qp_mem_rpatch0};
            R_LEAF:  rd64 = wbs_leaf_mem_rleaf0[bank_q];
            R_BEST:  rd64 = wbs_best_arr_rdata1;
            R_NODE:  rd64 = {32'b0, wbs_node_mem_rdata};
            default: rd64 = '0;
        endcase
    end

    // Node reads are a single word, so adr[2] never selects a half there
    assign rd_half = (up_q && rgn_q != R_NODE) ? rd64[63:32] : rd64[31:0];

    always_comb begin
        if (wbs_adr_i == 32'h3000_0000)
            reg_rd = {31'b0, mode_q};
        else if (wbs_adr_i == 32'h3000_0004)
            reg_rd = {31'b0, debug_q};
        else
            reg_rd = '0;
    end

    always_comb begin
        state_d  = state_q;
        rgn_d    = rgn_q;
        up_d     = up_q;
        bank_d   = bank_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
        mode_d   = mode_q;
        debug_d  = debug_q;
        hold_d   = hold_q;
        qcsb_d   = 1'b1;
        qweb_d   = 1'b1;
        qaddr_d  = qaddr_q;
        wpatch_d = wpatch_q;
        lcsb_d   = '1;
        lweb_d   = '1;
        laddr_d  = laddr_q;
        wleaf_d  = wleaf_q;
        nweb_d   = 1'b0;
        naddr_d  = naddr_q;
        nwdata_d = nwdata_q;
        bcsb_d   = 1'b1;
        baddr_d  = baddr_q;
        unique case (state_q)
            IDLE: if (wbs_cyc_i && wbs_stb_i) begin
                rgn_d  = rgn;
                up_d   = up;
                bank_d = bank;
                if (!wbs_we_i) begin
                    state_d = MREQ;
                    unique case (rgn)
                        R_QP: begin
                            qcsb_d  = 1'b0;
                            qaddr_d = wbs_adr_i[3+:QW];
                        end
                        R_LEAF: begin
                            lcsb_d[bank] = 1'b0;
                            laddr_d      = wbs_adr_i[6+:LW];
                        end
                        R_BEST: begin
                            bcsb_d  = 1'b0;
                            baddr_d = wbs_adr_i[3+:8];
                        end
                        R_NODE: naddr_d = {16'b0, wbs_adr_i[15:0]};
                        R_REG: begin
                            state_d = ACK;
                            ack_d   = 1'b1;
                            dat_d   = reg_rd;
                        end
                        default: begin
                            state_d = ACK;
                            ack_d   = 1'b1;
                            dat_d   = '0;
                        end
                    endcase
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    unique case (rgn)
                        R_REG: begin
                            if (wbs_adr_i == 32'h3000_0000)
                                mode_d = wbs_dat_i[0];
                            else if (wbs_adr_i == 32'h3000_0004)
                                debug_d = wbs_dat_i[0];
                        end
                        R_QP: begin
                            if (!up) begin
                                hold_d = wbs_dat_i;
                            end else begin
                                qcsb_d   = 1'b0;
                                qweb_d   = 1'b0;
                                qaddr_d  = wbs_adr_i[3+:QW];
                                wpatch_d = {wbs_dat_i[PW-33:0], hold_q};
                            end
                        end
                        R_LEAF: begin
                            if (!up) begin
                                hold_d = wbs_dat_i;
                            end else begin
                                lcsb_d[bank] = 1'b0;
                                lweb_d[bank] = 1'b0;
                                laddr_d      = wbs_adr_i[6+:LW];
                                wleaf_d      = {wbs_dat_i, hold_q};
                            end
                        end
                        R_NODE: begin
                            nweb_d   = 1'b1;
                            naddr_d  = {16'b0, wbs_adr_i[15:0]};
                            nwdata_d = wbs_dat_i;
                        end
                        default: ;
                    endcase
                end
            end
            MREQ:  state_d = MWAIT;
            MWAIT: begin
                state_d = ACK;
                ack_d   = 1'b1;
                dat_d   = rd_half;
            end
            ACK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            rgn_q    <= R_NONE;
            up_q     <= 1'b0;
            bank_q   <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            mode_q   <= 1'b0;
            debug_q  <= 1'b0;
            hold_q   <= '0;
            qcsb_q   <= 1'b1;
            qweb_q   <= 1'b1;
            qaddr_q  <= '0;
            wpatch_q <= '0;
            lcsb_q   <= '1;
            lweb_q   <= '1;
            laddr_q  <= '0;
            wleaf_q  <= '0;
            nweb_q   <= 1'b0;
            naddr_q  <= '0;
            nwdata_q <= '0;
            bcsb_q   <= 1'b1;
            baddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            rgn_q    <= rgn_d;
            up_q     <= up_d;
            bank_q   <= bank_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            mode_q   <= mode_d;
            debug_q  <= debug_d;
            hold_q   <= hold_d;
            qcsb_q   <= qcsb_d;
            qweb_q   <= qweb_d;
            qaddr_q  <= qaddr_d;
            wpatch_q <= wpatch_d;
            lcsb_q   <= lcsb_d;
            lweb_q   <= lweb_d;
            laddr_q  <= laddr_d;
            wleaf_q  <= wleaf_d;
            nweb_q   <= nweb_d;
            naddr_q  <= naddr_d;
            nwdata_q <= nwdata_d;
            bcsb_q   <= bcsb_d;
            baddr_q  <= baddr_d;
        end
    end

    assign wbs_ack_o           = ack_q;
    assign wbs_dat_o           = dat_q;
    assign wbs_mode            = mode_q;
    assign wbs_debug           = debug_q;
    assign wbs_qp_mem_csb0     = qcsb_q;
    assign wbs_qp_mem_web0     = qweb_q;
    assign wbs_qp_mem_addr0    = qaddr_q;
    assign wbs_qp_mem_wpatch0  = wpatch_q;
    assign wbs_leaf_mem_csb0   = lcsb_q;
    assign wbs_leaf_mem_web0   = lweb_q;
    assign wbs_leaf_mem_addr0  = laddr_q;
    assign wbs_leaf_mem_wleaf0 = wleaf_q;
    assign wbs_node_mem_web    = nweb_q;
    assign wbs_node_mem_addr   = naddr_q;
    assign wbs_node_mem_wdata  = nwdata_q;
    assign wbs_best_arr_csb1   = bcsb_q;
    assign wbs_best_arr_addr1  = baddr_q;

endmodule

// File: tb/tb_wbs_ctrl.sv
// Scoreboard bench for wbs_ctrl: directed bus accesses, a monitor checks
// dat_o at every ack, a strobe logger records memory-side activity.
module tb_wbs_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stb = 0, cyc = 0, we = 0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_i = 0, adr = 0;
    logic        ack;
    logic [31:0] dat_o;
    logic        mode, debug;
    logic        qcsb, qweb;
    logic [8:0]  qaddr;
    logic [54:0] wpatch, rpatch;
    logic [7:0]  lcsb, lweb;
    logic [5:0]  laddr;
    logic [63:0] wleaf;
    logic [63:0] rleaf [8];
    logic        nweb;
    logic [31:0] naddr, nwdata, nrdata;
    logic        bcsb;
    logic [7:0]  baddr;
    logic [63:0] brdata;

    wbs_ctrl dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .wbs_mode(mode), .wbs_debug(debug),
        .wbs_qp_mem_csb0(qcsb), .wbs_qp_mem_web0(qweb),
        .wbs_qp_mem_addr0(qaddr), .wbs_qp_mem_wpatch0(wpatch),
        .wbs_qp_mem_rpatch0(rpatch),
        .wbs_leaf_mem_csb0(lcsb), .wbs_leaf_mem_web0(lweb),
        .wbs_leaf_mem_addr0(laddr), .wbs_leaf_mem_wleaf0(wleaf),
        .wbs_leaf_mem_rleaf0(rleaf),
        .wbs_node_mem_web(nweb), .wbs_node_mem_addr(naddr),
        .wbs_node_mem_wdata(nwdata), .wbs_node_mem_rdata(nrdata),
        .wbs_best_arr_csb1(bcsb), .wbs_best_arr_addr1(baddr),
        .wbs_best_arr_rdata1(brdata)
    );

    logic [31:0] nmem [256];
    always @(posedge clk) if (nweb) nmem[naddr[7:0]] <= nwdata;
    assign nrdata = nmem[naddr[7:0]];

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];
    logic [31:0] last_dat = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got dat_o %h want no ack", dat_o);
            end else begin
                e = sbq.pop_front();
                chk(e.nm, {32'b0, dat_o}, {32'b0, e.d});
            end
        end
    end

    int          qn, ln, bn, nn;
    logic        qw, lw;
    logic [8:0]  qa;
    logic [54:0] qwp;
    logic [7:0]  lm;
    logic [5:0]  la;
    logic [63:0] lwd;
    logic [7:0]  ba;
    logic [31:0] na, nwd;

    always @(negedge clk) begin
        if (!qcsb) begin
            qn++; qa = qaddr; qwp = wpatch;
            if (!qweb) qw = 1;
        end
        if (lcsb != 8'hFF) begin
            ln++; lm = ~lcsb; la = laddr; lwd = wleaf;
            if (lweb != 8'hFF) lw = 1;
        end
        if (!bcsb) begin
            bn++; ba = baddr;
        end
        if (nweb) begin
            nn++; na = naddr; nwd = nwdata;
        end
    end

    task automatic bus(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string nm,
                       input logic [31:0] rexp);
        bit got = 0;
        if (!w) last_dat = rexp;
        sbq.push_back('{nm, last_dat});
        @(negedge clk);
        qn = 0; ln = 0; bn = 0; nn = 0; qw = 0; lw = 0;
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
        #1;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no ack want ack", nm);
            sbq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) nmem[i] = 0;
        for (int i = 0; i < 8; i++) rleaf[i] = {32'hA0A0_0000 + i, 32'h5050_0000 + i};
        rleaf[7] = 64'h1100_1010_DEADBEEF;
        rpatch = 55'h00_1010_DEADBEEF;
        brdata = 64'h1100_1010_DEADBEEF;

        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_mode_debug", {mode, debug}, 0);
        chk("rst_csb", {qcsb, qweb, lcsb, lweb, bcsb}, 19'h7FFFF);
        chk("rst_node_web", nweb, 0);
        chk("rst_addrs", {qaddr, laddr, baddr, naddr}, 0);
        rst_n = 1;

        bus(1, 32'h3000_0004, 1, "wr_debug", 0);
        chk("debug_set", {mode, debug}, 2'b01);
        bus(1, 32'h3000_0000, 1, "wr_mode", 0);
        chk("mode_set", {mode, debug}, 2'b11);
        bus(1, 32'h3000_0004, 0, "wr_debug0", 0);
        chk("debug_clr", {mode, debug}, 2'b10);
        bus(0, 32'h3000_0000, 0, "rd_mode", 32'h1);
        bus(0, 32'h3000_0008, 0, "rd_done", 32'h0);

        bus(0, 32'h3001_0008, 0, "rd_qp_lo", 32'hDEADBEEF);
        chk("qp_rd_strobe", {qn[7:0], qa, qw}, {8'd1, 9'd1, 1'b0});
        bus(0, 32'h3001_000C, 0, "rd_qp_hi", 32'h0000_1010);
        chk("qp_rd_hi_strobe", {qn[7:0], qa}, {8'd1, 9'd1});
        bus(1, 32'h3001_0010, 32'h0123_4567, "wr_qp_lo", 0);
        chk("qp_wr_lo_none", qn, 0);
        bus(1, 32'h3001_0014, 32'h000B_CDEF, "wr_qp_hi", 0);
        chk("qp_wr_strobe", {qn[7:0], qa, qw}, {8'd1, 9'd2, 1'b1});
        chk("qp_wpatch", qwp, 55'h0BCDEF_01234567);

        bus(0, 32'h3002_0038, 0, "rd_leaf_lo", 32'hDEADBEEF);
        chk("leaf_rd_strobe", {ln[7:0], lm, la, lw}, {8'd1, 8'h80, 6'd0, 1'b0});
        bus(0, 32'h3002_003C, 0, "rd_leaf_hi", 32'h1100_1010);
        bus(1, 32'h3002_0018, 32'h7654_3210, "wr_leaf_lo", 0);
        chk("leaf_wr_lo_none", ln, 0);
        bus(1, 32'h3002_001C, 32'hFEDC_BA98, "wr_leaf_hi", 0);
        chk("leaf_wr_strobe", {ln[7:0], lm, la, lw}, {8'd1, 8'h08, 6'd0, 1'b1});
        chk("leaf_wdata", lwd, 64'hFEDCBA98_76543210);

        bus(0, 32'h3003_0038, 0, "rd_best_lo", 32'hDEADBEEF);
        chk("best_rd_strobe", {bn[7:0], ba}, {8'd1, 8'd7});
        bus(0, 32'h3003_003C, 0, "rd_best_hi", 32'h1100_1010);
        bus(1, 32'h3003_0010, 32'h5555_AAAA, "wr_best", 0);
        chk("best_wr_none", {bn, qn, ln, nn}, 0);

        bus(1, 32'h3004_0002, 32'h0001_B801, "wr_node0", 0);
        chk("node_wr0", {nn[7:0], na, nwd}, {8'd1, 32'h2, 32'h0001_B801});
        bus(0, 32'h3004_0002, 0, "rd_node0", 32'h0001_B801);
        chk("node_rd_no_web", nn, 0);
        bus(1, 32'h3004_003F, 32'h0001_5002, "wr_node1", 0);
        chk("node_wr1", {nn[7:0], na, nwd}, {8'd1, 32'h3F, 32'h0001_5002});
        bus(0, 32'h3004_003F, 0, "rd_node1", 32'h0001_5002);

        bus(1, 32'h4000_0010, 32'hFFFF_FFFF, "wr_unmapped", 0);
        chk("unmapped_wr_none", {qn, ln, bn, nn, mode, debug}, {128'b0, 2'b10});
        bus(0, 32'h4000_0010, 0, "rd_unmapped", 32'h0);

        bus(1, 32'h3001_0010, 32'h1111_1111, "wr_qp_lo2", 0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3001_0008;
        @(negedge clk);
        chk("abort_csb_lo", qcsb, 0);
        rst_n = 0;
        #1;
        chk("abort_outputs", {qcsb, ack, mode, dat_o}, {1'b1, 1'b0, 1'b0, 32'h0});
        cyc = 0; stb = 0;
        @(negedge clk);
        rst_n = 1;
        last_dat = 0;
        bus(1, 32'h3001_0014, 32'h000B_CDEF, "wr_qp_hi2", 0);
        chk("hold_cleared", qwp, 55'h0BCDEF_00000000);

        repeat (3) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
